// File: rtl/approx_wallace_mac_controller_pkg.sv
// approx_mac_pkg: shared state enum, product width and default sizing for the approximate MAC controller
package approx_mac_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;
  localparam int PROD_W        = 16;
  localparam int DEF_MAX_TERMS = 16;
  localparam int DEF_LEN_W     = 5;
  localparam int DEF_ACC_W     = 20;
endpackage

// File: rtl/approx_wallace_mac_controller_if.sv
// approx_wallace_mac_controller_if: job, operand-stream and result signals of the MAC controller
// master: operand source / result consumer; slave: the controller.
interface approx_wallace_mac_controller_if #(
  parameter int LEN_W = approx_mac_pkg::DEF_LEN_W,
  parameter int ACC_W = approx_mac_pkg::DEF_ACC_W
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;
  logic             busy;
  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );
  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/approx_wallace_mac_controller_mult.sv
// approx_eight_bit_wallace_tree: combinational approximate 8x8 unsigned multiplier
// Ports: a_i, b_i (8-bit operands), p_o (16-bit approximate product).
// Columns 0..3 are compressed with OR instead of adders (no carries out of
// them); columns 4..14 are summed exactly, the reduction tree is left to synthesis.
module approx_eight_bit_wallace_tree (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [15:0] row [8];
  logic [3:0]  low;
  for (genvar j = 0; j < 8; j++) begin : g_row
    assign row[j] = (16'(a_i & {8{b_i[j]}}) << j) & 16'hfff0;
  end
  assign low[0] = a_i[0] & b_i[0];
  assign low[1] = (a_i[1] & b_i[0]) | (a_i[0] & b_i[1]);
  assign low[2] = (a_i[2] & b_i[0]) | (a_i[1] & b_i[1]) | (a_i[0] & b_i[2]);
  assign low[3] = (a_i[3] & b_i[0]) | (a_i[2] & b_i[1]) | (a_i[1] & b_i[2]) | (a_i[0] & b_i[3]);
  always_comb
    p_o = row[0] + row[1] + row[2] + row[3] + row[4] + row[5] + row[6] + row[7] + {12'd0, low};
endmodule

// File: rtl/approx_wallace_mac_controller.sv
// approx_wallace_mac_controller: streaming multiply-accumulate sequencer around the approximate multiplier
// Ports: clk, rst (async, active-high), bus (slave side of the controller interface:
// start/len job request, in_valid/in_ready/a/b operand stream,
// out_valid/out_ready/result result port, overflow and busy status).
module approx_wallace_mac_controller import approx_mac_pkg::*; #(
  parameter int MAX_TERMS = DEF_MAX_TERMS,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int ACC_W     = DEF_ACC_W
) (
  input logic clk,
  input logic rst,
  approx_wallace_mac_controller_if.slave bus
);
  mac_state_t        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d, len_c;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0] p_q, p_d, prod;
  logic              p_v_q, p_v_d, ovf_q, ovf_d, xfer;
  logic [ACC_W:0]    sum;
  approx_eight_bit_wallace_tree u_mult (
    .a_i(bus.a),
    .b_i(bus.b),
    .p_o(prod)
  );
  always_comb begin
    len_c         = bus.len > LEN_W'(MAX_TERMS) ? LEN_W'(MAX_TERMS) : bus.len;
    bus.in_ready  = state_q == RUN && rem_q != '0;
    bus.out_valid = state_q == DONE;
    bus.busy      = state_q != IDLE;
    bus.result    = acc_q;
    bus.overflow  = ovf_q;
    xfer          = bus.in_valid && bus.in_ready;
    sum           = {1'b0, acc_q} + (ACC_W+1)'(p_q);
    state_d       = state_q;
    rem_d         = rem_q;
    p_d           = p_q;
    p_v_d         = p_v_q;
    // p_v is only ever set in RUN and cleared by DRAIN, so this add covers both states
    acc_d         = p_v_q ? sum[ACC_W-1:0] : acc_q;
    ovf_d         = ovf_q | (p_v_q & sum[ACC_W]);
    case (state_q)
      IDLE: if (bus.start) begin
        rem_d   = len_c;
        acc_d   = '0;
        ovf_d   = 1'b0;
        p_v_d   = 1'b0;
        state_d = len_c == '0 ? DONE : RUN;
      end
      RUN: begin
        p_v_d   = xfer;
        p_d     = xfer ? prod : p_q;
        rem_d   = xfer ? rem_q - 1'b1 : rem_q;
        state_d = xfer && rem_q == LEN_W'(1) ? DRAIN : RUN;
      end
      DRAIN: begin
        p_v_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      p_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      p_v_q   <= p_v_d;
    end
endmodule

// File: tb/tb_approx_wallace_mac_controller.sv
// tb_approx_wallace_mac_controller: directed self-checking bench for the approximate MAC controller
module tb_approx_wallace_mac_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  approx_wallace_mac_controller_if #(.LEN_W(5), .ACC_W(20)) m ();
  approx_wallace_mac_controller_if #(.LEN_W(5), .ACC_W(16)) n ();
  approx_wallace_mac_controller #(.MAX_TERMS(16), .LEN_W(5), .ACC_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(m)
  );
  approx_wallace_mac_controller #(.MAX_TERMS(16), .LEN_W(5), .ACC_W(16)) dut16 (
    .clk(clk),
    .rst(rst),
    .bus(n)
  );
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] exp;
  } vec_t;
  vec_t       vecs [10];
  logic [7:0] op_a [32];
  logic [7:0] op_b [32];
  int         nvec = 0;
  int         nerr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic int model(input int a, input int b);
    int lo_ex, lo_or, t;
    lo_ex = 0;
    lo_or = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++) begin
        t = ((a >> i) & 1) & ((b >> j) & 1);
        lo_ex += t << (i + j);
        lo_or |= t << (i + j);
      end
    return a * b - lo_ex + lo_or;
  endfunction
  task automatic start_job(input logic [4:0] l);
    m.start = 1'b1;
    m.len   = l;
    cyc();
    m.start = 1'b0;
  endtask
  task automatic feed(input int cnt, input bit rnd, output int k, output int cycles);
    k      = 0;
    cycles = 0;
    while (k < cnt && cycles < 200) begin
      m.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m.a        = op_a[k];
      m.b        = op_b[k];
      if (m.in_valid && m.in_ready) k++;
      cyc();
      cycles++;
    end
    m.in_valid = 1'b0;
  endtask
  task automatic wait_out();
    int t;
    t = 0;
    while (!m.out_valid && t < 50) begin
      cyc();
      t++;
    end
    chk("out_valid_wait", 32'(m.out_valid), 1);
  endtask
  task automatic handshake();
    m.out_ready = 1'b1;
    cyc();
    m.out_ready = 1'b0;
    chk("idle_after_handshake", 32'(m.busy), 0);
  endtask
  initial begin
    int k, c, exp;
    vecs[0] = '{8'd0,   8'd0,   20'd0};
    vecs[1] = '{8'd1,   8'd1,   20'd1};
    vecs[2] = '{8'd3,   8'd3,   20'd7};
    vecs[3] = '{8'd5,   8'd5,   20'd21};
    vecs[4] = '{8'd2,   8'd3,   20'd6};
    vecs[5] = '{8'd7,   8'd9,   20'd63};
    vecs[6] = '{8'd15,  8'd15,  20'd191};
    vecs[7] = '{8'd16,  8'd16,  20'd256};
    vecs[8] = '{8'd200, 8'd100, 20'd20000};
    vecs[9] = '{8'd255, 8'd255, 20'd64991};
    {m.start, m.len, m.in_valid, m.a, m.b, m.out_ready} = '0;
    {n.start, n.len, n.in_valid, n.a, n.b, n.out_ready} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(m.in_ready), 0);
    chk("rst_out_valid", 32'(m.out_valid), 0);
    chk("rst_busy", 32'(m.busy), 0);
    chk("rst_overflow", 32'(m.overflow), 0);
    chk("rst_result", 32'(m.result), 0);
    rst = 1'b0;
    cyc();
    start_job(5'd0);
    chk("len0_out_valid", 32'(m.out_valid), 1);
    chk("len0_result", 32'(m.result), 0);
    chk("len0_overflow", 32'(m.overflow), 0);
    chk("len0_in_ready", 32'(m.in_ready), 0);
    handshake();
    for (int i = 0; i < 32; i++) begin
      op_a[i] = 8'd0;
      op_b[i] = 8'd0;
    end
    start_job(5'd4);
    feed(4, 1'b0, k, c);
    chk("zero_accepts", k, 4);
    chk("zero_accept_cycles", c, 4);
    chk("zero_ov_after_last", 32'(m.out_valid), 0);
    cyc();
    chk("zero_ov_2cyc", 32'(m.out_valid), 1);
    chk("zero_result", 32'(m.result), 0);
    handshake();
    exp = 0;
    for (int i = 0; i < 16; i++) begin
      op_a[i] = 8'($urandom);
      op_b[i] = 8'($urandom);
      exp += model(int'(op_a[i]), int'(op_b[i]));
    end
    start_job(5'd16);
    feed(16, 1'b1, k, c);
    chk("rand_accepts", k, 16);
    chk("rand_ready_drop", 32'(m.in_ready), 0);
    wait_out();
    chk("rand_result", 32'(m.result), exp);
    chk("rand_overflow", 32'(m.overflow), 0);
    handshake();
    for (int i = 0; i < 32; i++) begin
      op_a[i] = 8'd1;
      op_b[i] = 8'd1;
    end
    start_job(5'd31);
    feed(16, 1'b0, k, c);
    chk("clamp_accepts", k, 16);
    chk("clamp_ready_drop", 32'(m.in_ready), 0);
    wait_out();
    chk("clamp_result", 32'(m.result), 16);
    handshake();
    for (int v = 0; v < 10; v++) begin
      op_a[0] = vecs[v].a;
      op_b[0] = vecs[v].b;
      start_job(5'd1);
      feed(1, 1'b0, k, c);
      cyc();
      chk($sformatf("vec%0d_out_valid", v), 32'(m.out_valid), 1);
      chk($sformatf("vec%0d_result", v), 32'(m.result), 32'(vecs[v].exp));
      handshake();
    end
    op_a[0] = 8'd5;
    op_b[0] = 8'd5;
    start_job(5'd1);
    feed(1, 1'b0, k, c);
    cyc();
    for (int i = 0; i < 5; i++) begin
      m.start = i == 2;
      m.len   = 5'd3;
      chk($sformatf("hold%0d_out_valid", i), 32'(m.out_valid), 1);
      chk($sformatf("hold%0d_result", i), 32'(m.result), 21);
      cyc();
    end
    m.start     = 1'b0;
    m.out_ready = 1'b1;
    cyc();
    m.out_ready = 1'b0;
    chk("hold_idle", 32'(m.busy), 0);
    cyc();
    chk("hold_start_ignored", 32'(m.busy), 0);
    n.start = 1'b1;
    n.len   = 5'd2;
    cyc();
    n.start    = 1'b0;
    n.in_valid = 1'b1;
    n.a        = 8'd255;
    n.b        = 8'd255;
    chk("acc16_in_ready", 32'(n.in_ready), 1);
    cyc();
    cyc();
    n.in_valid = 1'b0;
    chk("acc16_ready_drop", 32'(n.in_ready), 0);
    cyc();
    chk("acc16_out_valid", 32'(n.out_valid), 1);
    chk("acc16_result", 32'(n.result), 64446);
    chk("acc16_overflow", 32'(n.overflow), 1);
    n.out_ready = 1'b1;
    cyc();
    n.out_ready = 1'b0;
    n.start     = 1'b1;
    n.len       = 5'd1;
    cyc();
    n.start = 1'b0;
    chk("acc16_overflow_cleared", 32'(n.overflow), 0);
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 8'd200;
      op_b[i] = 8'd100;
    end
    start_job(5'd8);
    feed(3, 1'b0, k, c);
    chk("rstjob_accepts", k, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(m.in_ready), 0);
    chk("arst_busy", 32'(m.busy), 0);
    chk("arst_out_valid", 32'(m.out_valid), 0);
    chk("arst_overflow", 32'(m.overflow), 0);
    chk("arst_result", 32'(m.result), 0);
    #1;
    rst = 1'b0;
    cyc();
    op_a[0] = 8'd3;
    op_b[0] = 8'd3;
    start_job(5'd1);
    feed(1, 1'b0, k, c);
    chk("post_rst_accepts", k, 1);
    cyc();
    chk("post_rst_out_valid", 32'(m.out_valid), 1);
    chk("post_rst_result", 32'(m.result), 7);
    handshake();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/approx_wallace_mac_controller.md
# approx_wallace_mac_controller

Sequencing controller that turns the approximate 8-bit Wallace tree multiplier into a streaming multiply-accumulate (dot-product) engine. It accepts a job length, pulls `len` operand pairs over a valid/ready handshake, registers each approximate product, and accumulates the products into a wide accumulator. It presents the final sum on an output valid/ready port. It sits between an operand source (memory reader or test driver) and the result consumer, and is the only block that drives the multiplier's operand inputs.

## Interface
- `MAX_TERMS`, 16: largest legal job length.
- `LEN_W`, 5: width of `len`; must satisfy 2^LEN_W > MAX_TERMS.
- `ACC_W`, 20: accumulator and result width. The default holds 16 × 255 × 255 without wrap.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of products in the job, sampled with `start`. Values above MAX_TERMS are clamped to MAX_TERMS.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller accepts an operand pair this cycle.
- `a`, `b`  in  8 each  unsigned operands.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- `overflow`  out  1  sticky flag: the accumulator wrapped at least once during the current or last job.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=0 and `out_valid`=0.
  - `start`=1 loads `remaining` with `len` (clamped), clears `acc`, clears `overflow` and clears the product-valid bit `p_v`.
  - If `len`=0, the next state is DONE with `result`=0. Otherwise the next state is RUN.
- RUN:
  - `in_ready` = (`remaining` != 0).
  - On `in_valid && in_ready`:
    - `p_q` ← approximate product of `a` and `b` (16 bits).
    - `p_v` ← 1.
    - `remaining` decrements.
  - If no transfer occurs, `p_v` ← 0.
  - Every cycle with `p_v`=1, `acc` ← `acc` + zero-extended `p_q`. A carry out of bit ACC_W-1 sets `overflow`.
  - When the transfer that takes `remaining` from 1 to 0 occurs, the next state is DRAIN.
- DRAIN: `in_ready`=0. The final product is added, `p_v` clears, and the next state is DONE.
- DONE:
  - `out_valid`=1 and `result`=`acc`; both are held stable until `out_ready`=1.
  - The handshake cycle returns the controller to IDLE. `acc` and `overflow` keep their values; `result` is only defined while `out_valid`=1.
- `start` outside IDLE is ignored; it is not queued.
- The multiplier's operand inputs are driven directly from `a` and `b`. Only transfers (`in_valid && in_ready`) are captured.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `overflow`=0.
  - `result`=0, `acc`=0, `p_q`=0, `p_v`=0, `remaining`=0.
- Reset mid-job abandons the job immediately. No partial result is produced.
- Sustained throughput is one operand pair per cycle in RUN.
- Latency: if the last pair is accepted at edge k, `acc` is final at edge k+1 and `out_valid` rises after edge k+1. That is 2 cycles from the last accept to `out_valid`.
- From the `start` edge to the first possible accept is 1 cycle, because `in_ready` rises after the IDLE→RUN edge.
- `len`=0: `out_valid` rises 1 cycle after `start`.
- Back-to-back jobs: `start` may be asserted in the first IDLE cycle after the output handshake. The minimum gap between a result handshake and the next accepted operand is 2 cycles.
- `out_ready` held high during DONE gives a 1-cycle `out_valid` pulse.

## Structure
- Shared package `approx_mac_pkg`:
  - state enum `mac_state_t` (IDLE, RUN, DRAIN, DONE).
  - `PROD_W`=16.
  - default `MAX_TERMS`, `LEN_W` and `ACC_W`.
- One sub-module: a single instance of the existing `approx_eight_bit_wallace_tree` multiplier (8×8 → 16), combinational. The controller registers its output in `p_q`.
- The FSM, counter and accumulator all live in the controller itself.

## Test plan
- Reset, then `start` with `len`=0 → `out_valid` one cycle later, `result`=0, `overflow`=0, `in_ready` never high.
- `len`=4, all operands `a`=0 and `b`=0, `in_valid` held high → 4 accepts on consecutive cycles, `result`=0, `out_valid` 2 cycles after the 4th accept.
- `len`=16 with random operands and `in_valid` toggled randomly → `result` equals the sum of the approximate multiplier model's outputs. `in_ready` drops after exactly 16 accepts. `overflow`=0.
- Build with `ACC_W`=16, `len`=2, `a`=`b`=255 → `result` = (2 × model(255,255)) mod 65536 and `overflow`=1. On the next `start`, `overflow` reads 0.
- `out_ready` held low for 5 DONE cycles with `start` pulsed meanwhile → `result` stable, `start` ignored, return to IDLE only on the handshake.
- Assert `rst` after 3 of 8 accepts → all outputs read their reset values asynchronously. A fresh `len`=1 job then completes normally.
